// File: rtl/mem_bist_if.sv
// Requester/responder bus between the BIST initiator and the memory it exercises.
interface mem_bist_if #(
  parameter int AW    = 5,
  parameter int WIDTH = 8
);
  logic             read;
  logic             write;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (output read, output write, output addr, output data_in, input data_out);
  modport slave  (input read, input write, input addr, input data_in, output data_out);
endinterface

// File: rtl/mem_bist_initiator.sv
// March-style memory BIST: write P, read/compare P, write ~P, read/compare ~P,
// then report pass, saturating error count and first failing address.
module mem_bist_initiator #(
  parameter int               DEPTH = 32,
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5),
  parameter int               AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [AW-1:0] first_fail_addr,
  mem_bist_if.master    mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_R0, S_D0, S_W1, S_R1, S_D1, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             read_q, read_d, write_q, write_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic [AW-1:0]    cmp_addr_q, cmp_addr_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [AW-1:0]    ffa_q, ffa_d;

  logic [AW-1:0]    nxt_addr_s;
  logic             last_s;
  logic             mismatch_s;

  // P(a) = zero-extended a XOR SEED, optionally inverted
  function automatic logic [WIDTH-1:0] pattern(input logic [AW-1:0] a, input logic inv);
    logic [AW+WIDTH-1:0] ext;
    ext = {{WIDTH{1'b0}}, a};
    return ext[WIDTH-1:0] ^ SEED ^ {WIDTH{inv}};
  endfunction

  assign nxt_addr_s = addr_q + AW'(1);
  assign last_s     = (addr_q == AW'(DEPTH - 1));
  assign mismatch_s = cmp_vld_q && (mem.data_out != cmp_exp_q);

  // Next-state, strobe and compare-pipeline logic
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addr_d      = addr_q;
    data_in_d   = {WIDTH{1'b0}};
    exp_d       = exp_q;
    cmp_vld_d   = read_q;
    cmp_exp_d   = exp_q;
    cmp_addr_d  = addr_q;
    err_count_d = err_count_q;
    ffa_d       = ffa_q;

    // Read data arrives one cycle after the read strobe is sampled by the memory
    if (mismatch_s) begin
      err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
      ffa_d       = (err_count_q == 8'd0) ? cmp_addr_q : ffa_q;
    end else begin
      err_count_d = err_count_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_W0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = 8'd0;
          ffa_d       = {AW{1'b0}};
          write_d     = 1'b1;
          addr_d      = {AW{1'b0}};
          data_in_d   = pattern({AW{1'b0}}, 1'b0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W0, S_W1: begin
        if (last_s) begin
          state_d = (state_q == S_W0) ? S_R0 : S_R1;
          read_d  = 1'b1;
          addr_d  = {AW{1'b0}};
          exp_d   = pattern({AW{1'b0}}, state_q == S_W1);
        end else begin
          write_d   = 1'b1;
          addr_d    = nxt_addr_s;
          data_in_d = pattern(nxt_addr_s, state_q == S_W1);
        end
      end
      S_R0, S_R1: begin
        if (last_s) begin
          state_d = (state_q == S_R0) ? S_D0 : S_D1;
          addr_d  = {AW{1'b0}};
        end else begin
          read_d = 1'b1;
          addr_d = nxt_addr_s;
          exp_d  = pattern(nxt_addr_s, state_q == S_R1);
        end
      end
      S_D0: begin
        state_d   = S_W1;
        write_d   = 1'b1;
        addr_d    = {AW{1'b0}};
        data_in_d = pattern({AW{1'b0}}, 1'b1);
      end
      S_D1: begin
        state_d = S_FIN;
        busy_d  = 1'b0;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        pass_d  = (err_count_q == 8'd0);
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= {AW{1'b0}};
      data_in_q   <= {WIDTH{1'b0}};
      exp_q       <= {WIDTH{1'b0}};
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= {WIDTH{1'b0}};
      cmp_addr_q  <= {AW{1'b0}};
      err_count_q <= 8'd0;
      ffa_q       <= {AW{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      exp_q       <= exp_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      err_count_q <= err_count_d;
      ffa_q       <= ffa_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_fail_addr = ffa_q;
  assign mem.read        = read_q;
  assign mem.write       = write_q;
  assign mem.addr        = addr_q;
  assign mem.data_in     = data_in_q;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Directed bench: 32x8 BIST against a fault-injectable memory model, plus a
// 256-deep instance against an all-zero memory to exercise error saturation.
module tb_mem_bist_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [4:0] ffa;
  logic       busy2, done2, pass2;
  logic [7:0] err_count2;
  logic [7:0] ffa2;

  int checks = 0;
  int errors = 0;

  mem_bist_if #(.AW(5), .WIDTH(8)) mif ();
  mem_bist_if #(.AW(8), .WIDTH(8)) mif2 ();

  mem_bist_initiator #(.DEPTH(32), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_addr(ffa), .mem(mif)
  );

  mem_bist_initiator #(.DEPTH(256), .WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_fail_addr(ffa2), .mem(mif2)
  );

  always #5 clk = ~clk;

  // Memory model with per-address stuck-at-0 / stuck-at-1 masks
  logic [7:0] mem_a [32];
  logic [7:0] sa0 [32];
  logic [7:0] sa1 [32];
  logic       zero_rd = 1'b0;

  always @(posedge clk) begin
    if (mif.write) mem_a[mif.addr] <= mif.data_in;
    if (mif.read)  mif.data_out <= zero_rd ? 8'h00 : ((mem_a[mif.addr] & ~sa0[mif.addr]) | sa1[mif.addr]);
  end

  assign mif2.data_out = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         done_cyc, busy_cyc, rw_viol, cyc;
  logic       wr0_write, done_at0;
  logic [4:0] wr0_addr;
  logic [7:0] wr0_data;
  logic [7:0] wr5 [$];

  task automatic clear_faults();
    for (int i = 0; i < 32; i++) begin
      sa0[i] = 8'h00;
      sa1[i] = 8'h00;
    end
    zero_rd = 1'b0;
  endtask

  // Pulse start, then step edge by edge until done or the cycle budget runs out
  task automatic do_run(input int pulse_a, input int pulse_b);
    wr5.delete();
    rw_viol = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    wr0_write = mif.write;
    wr0_addr  = mif.addr;
    wr0_data  = mif.data_in;
    done_at0  = done;
    busy_cyc  = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 2000) begin
      start = (cyc == pulse_a || cyc == pulse_b) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (mif.read && mif.write) rw_viol++;
      if (busy) busy_cyc++;
      if (mif.write && mif.addr == 5'd5) wr5.push_back(mif.data_in);
    end
    start = 1'b0;
    done_cyc = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_pass"},  {31'd0, pass}, 32'd0);
    chk({tag, "_rdwr"},  {30'd0, mif.read, mif.write}, 32'd0);
    chk({tag, "_addr"},  {27'd0, mif.addr}, 32'd0);
    chk({tag, "_din"},   {24'd0, mif.data_in}, 32'd0);
    chk({tag, "_err"},   {24'd0, err_count}, 32'd0);
    chk({tag, "_ffa"},   {27'd0, ffa}, 32'd0);
  endtask

  initial begin
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run
    do_run(-1, -1);
    chk("t1_wr0_strobe", {31'd0, wr0_write}, 32'd1);
    chk("t1_wr0_addr", {27'd0, wr0_addr}, 32'd0);
    chk("t1_wr0_data", {24'd0, wr0_data}, 32'h0000_00A5);
    chk("t1_wr5_count", wr5.size(), 32'd2);
    if (wr5.size() == 2) begin
      chk("t1_wr5_w0", {24'd0, wr5[0]}, 32'h0000_00A0);
      chk("t1_wr5_w1", {24'd0, wr5[1]}, 32'h0000_005F);
    end
    chk("t1_done_cyc", done_cyc, 32'd131);
    chk("t1_busy_cyc", busy_cyc, 32'd130);
    chk("t1_pass", {31'd0, pass}, 32'd1);
    chk("t1_err", {24'd0, err_count}, 32'd0);
    chk("t1_ffa", {27'd0, ffa}, 32'd0);
    chk("t1_rw_excl", rw_viol, 32'd0);

    // addr 5 bit 3 stuck-at-0: only the ~P phase (0x5F) is affected
    sa0[5] = 8'h08;
    do_run(-1, -1);
    chk("t2_done_at0", {31'd0, done_at0}, 32'd0);
    chk("t2_done_cyc", done_cyc, 32'd131);
    chk("t2_pass", {31'd0, pass}, 32'd0);
    chk("t2_err", {24'd0, err_count}, 32'd1);
    chk("t2_ffa", {27'd0, ffa}, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_persist_err", {24'd0, err_count}, 32'd1);
    chk("t2_persist_done", {31'd0, done}, 32'd1);

    // addr 9 bit0 sa1 (R0 miss), addr 20 bit7 sa0 (R0 miss) + bit0 sa1 (R1 miss)
    clear_faults();
    sa1[9]  = 8'h01;
    sa0[20] = 8'h80;
    sa1[20] = 8'h01;
    do_run(-1, -1);
    chk("t3_pass", {31'd0, pass}, 32'd0);
    chk("t3_err", {24'd0, err_count}, 32'd3);
    chk("t3_ffa", {27'd0, ffa}, 32'd9);

    // All reads zero on 32 deep: no address matches, 64 mismatches
    clear_faults();
    zero_rd = 1'b1;
    do_run(-1, -1);
    chk("t4_err", {24'd0, err_count}, 32'd64);
    chk("t4_ffa", {27'd0, ffa}, 32'd0);
    chk("t4_pass", {31'd0, pass}, 32'd0);

    // Reset mid R0 aborts, then a clean rerun
    clear_faults();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_abort");
    @(negedge clk);
    rst = 1'b0;
    rw_viol = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mif.read || mif.write || busy) rw_viol++;
    end
    chk("t5_quiet", rw_viol, 32'd0);
    do_run(-1, -1);
    chk("t5_done_cyc", done_cyc, 32'd131);
    chk("t5_pass", {31'd0, pass}, 32'd1);
    chk("t5_err", {24'd0, err_count}, 32'd0);

    // Start re-pulsed mid-run is ignored
    do_run(10, 70);
    chk("t6_done_cyc", done_cyc, 32'd131);
    chk("t6_busy_cyc", busy_cyc, 32'd130);
    chk("t6_rw_excl", rw_viol, 32'd0);
    chk("t6_pass", {31'd0, pass}, 32'd1);

    // 256-deep, all-zero reads: 510 mismatches saturate at 255
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t7_done_cyc", cyc, 32'd1027);
    chk("t7_err_sat", {24'd0, err_count2}, 32'd255);
    chk("t7_ffa", {24'd0, ffa2}, 32'd0);
    chk("t7_pass", {31'd0, pass2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
